s3_execute_stage: RTL
=====================

// Module: s3_execute_stage
// PURPOSE
//  Execute stage plus the S3 pipeline register; consumes the S2 register outputs.
//  - Selects operand B (register or sign-extended immediate) and runs the 3-bit ALUop.
//  - Forwards the previous S3 result into operands when the source register matches.
//  - Registers result, write select and write enable toward writeback, and counts retired writes.
// PARAMETERS
//  DATA_W      32  datapath width
//  IMM_W       16  immediate width, sign-extended to DATA_W
//  REG_ADDR_W  5   register-file address width
//  COUNT_W     16  retired-write counter width
// PORTS
//  clk             in   1           clock, all state updates on posedge
//  rst             in   1           synchronous reset, active-high
//  S2_ReadData1    in   DATA_W      operand A from S2
//  S2_ReadData2    in   DATA_W      operand B register value from S2
//  S2_Immediate    in   IMM_W       immediate from S2
//  S2_DataSource   in   1           1 = operand B is the immediate, 0 = register
//  S2_ALUop        in   3           ALU operation, encoding below
//  S2_ReadSelect1  in   REG_ADDR_W  source register number of operand A
//  S2_ReadSelect2  in   REG_ADDR_W  source register number of operand B
//  S2_WriteSelect  in   REG_ADDR_W  destination register
//  S2_WriteEnable  in   1           instruction writes the register file
//  S3_ALUResult    out  DATA_W      registered ALU result
//  S3_WriteSelect  out  REG_ADDR_W  registered destination
//  S3_WriteEnable  out  1           registered write enable
//  S3_Zero         out  1           registered flag, 1 when the result is 0
//  S3_RetireCount  out  COUNT_W     number of retired writes
// BEHAVIOUR
//  - The interface has one clock, clk, and uses a synchronous, active-high reset named rst.
//  - Reset: on a posedge with rst=1, every output is set to 0, including S3_RetireCount.
//    Reset has priority over all other inputs in that cycle.
//  - Latency: the S2 inputs at edge N are reflected on the S3 outputs after edge N.
//    There are no stalls; the stage accepts a new instruction every cycle.
//  - Immediate: ImmExt = {{(DATA_W-IMM_W){S2_Immediate[IMM_W-1]}}, S2_Immediate}.
//  - Forwarding (FwdA): S3_WriteEnable=1 and S3_WriteSelect!=0 and S3_WriteSelect==S2_ReadSelect1.
//    When FwdA holds, A = S3_ALUResult; otherwise A = S2_ReadData1.
//  - Forwarding (FwdB): the same condition, tested against S2_ReadSelect2.
//    FwdB applies only when S2_DataSource=0.
//  - Operand B: S2_DataSource=1 gives B = ImmExt.
//    Otherwise B = S3_ALUResult when FwdB holds, else S2_ReadData2.
//  - Register 0 is never forwarded.
//  - ALUop encodings:
//    000 B (move); 001 ~A; 010 A+B; 011 A-B; 100 A|B; 101 A&B; 110 signed A<B ? 1 : 0; 111 A^B.
//    Add and subtract wrap modulo 2^DATA_W. No carry or overflow output.
//  - S3_Zero is registered together with the result: (result == 0).
//  - S3_WriteSelect and S3_WriteEnable pass through unchanged, including when the write enable is 0.
//  - The ALU result is registered even when S2_WriteEnable=0.
//    Forwarding ignores that result because S3_WriteEnable=0.
//  - S3_RetireCount increments by 1 on each non-reset edge where S2_WriteEnable=1.
//    It wraps from all-ones to 0.
//  - Reset mid-stream: the cycle after reset has S3_WriteEnable=0, so no forwarding occurs.
//    The instruction present during the reset edge is discarded.
// TESTING
//  1. Reset: rst=1 for 2 cycles with random inputs.
//     -> all outputs 0; S3_RetireCount=0.
//  2. Immediate add: A=5, Imm=16'hFFFE, DataSource=1, ALUop=010, WS=3, WE=1.
//     -> next cycle: S3_ALUResult=3, S3_WriteSelect=3, S3_WriteEnable=1, S3_Zero=0, count=1.
//  3. Forwarding: first r4=10+20 (ALUop 010, WE=1, WS=4).
//     Next instruction: RS1=4, stale ReadData1=0, Imm=30, ALUop=011, DataSource=1.
//     -> S3_ALUResult=0, S3_Zero=1.
//  4. No forwarding: repeat test 3 with WS=0, or with WE=0 on the first instruction.
//     -> the stale ReadData1 is used. Also DataSource=1 with RS2 matching -> B is the immediate.
//  5. ALUop sweep with A=32'h8000_0000 and B=1: check all 8 results.
//     -> SLT=1, SUB=32'h7FFF_FFFF, XOR=32'h8000_0001.
//  6. Counter wrap with COUNT_W=4: 17 writes with WE=1 -> count=1.
//     Assert rst mid-burst -> count=0 and no forwarding on the following cycle.

Source files
------------

// File: rtl/s3_execute_stage.sv
// Execute stage with S3 pipeline register: operand select, forwarding,
// 3-bit ALU, writeback bundle and retired-write counter.
module s3_execute_stage #(
  parameter int DATA_W     = 32,
  parameter int IMM_W      = 16,
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     S2_ReadData1,
  input  logic [DATA_W-1:0]     S2_ReadData2,
  input  logic [IMM_W-1:0]      S2_Immediate,
  input  logic                  S2_DataSource,
  input  logic [2:0]            S2_ALUop,
  input  logic [REG_ADDR_W-1:0] S2_ReadSelect1,
  input  logic [REG_ADDR_W-1:0] S2_ReadSelect2,
  input  logic [REG_ADDR_W-1:0] S2_WriteSelect,
  input  logic                  S2_WriteEnable,
  output logic [DATA_W-1:0]     S3_ALUResult,
  output logic [REG_ADDR_W-1:0] S3_WriteSelect,
  output logic                  S3_WriteEnable,
  output logic                  S3_Zero,
  output logic [COUNT_W-1:0]    S3_RetireCount
);

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_y;
  logic              s3_live;
  logic              fwd_a;
  logic              fwd_b;
  logic              slt;

  assign imm_ext =
    {{(DATA_W-IMM_W){S2_Immediate[IMM_W-1]}}, S2_Immediate};

  // r0 is hardwired, so a pending write to it never forwards
  assign s3_live = S3_WriteEnable && (S3_WriteSelect != '0);
  assign fwd_a   = s3_live && (S3_WriteSelect == S2_ReadSelect1);
  assign fwd_b   = s3_live && (S3_WriteSelect == S2_ReadSelect2)
                   && !S2_DataSource;

  assign op_a = fwd_a ? S3_ALUResult : S2_ReadData1;

  always_comb begin
    op_b = S2_ReadData2;
    if (S2_DataSource)
      op_b = imm_ext;
    else if (fwd_b)
      op_b = S3_ALUResult;
  end

  assign slt = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_y = '0;
    unique case (S2_ALUop)
      3'b000: alu_y = op_b;
      3'b001: alu_y = ~op_a;
      3'b010: alu_y = op_a + op_b;
      3'b011: alu_y = op_a - op_b;
      3'b100: alu_y = op_a | op_b;
      3'b101: alu_y = op_a & op_b;
      3'b110: alu_y = {{(DATA_W-1){1'b0}}, slt};
      3'b111: alu_y = op_a ^ op_b;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S3_ALUResult   <= '0;
      S3_WriteSelect <= '0;
      S3_WriteEnable <= 1'b0;
      S3_Zero        <= 1'b0;
      S3_RetireCount <= '0;
    end else begin
      S3_ALUResult   <= alu_y;
      S3_WriteSelect <= S2_WriteSelect;
      S3_WriteEnable <= S2_WriteEnable;
      S3_Zero        <= (alu_y == '0);
      if (S2_WriteEnable)
        S3_RetireCount <= S3_RetireCount + COUNT_W'(1);
    end
  end

endmodule
